mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares the single-port program/data memory between the CPU and a second master, such as a switch-driven loader or debug port. It sits between the requesters and the memory's we/addr/data/out ports. It grants one access per clock, round-robin or fixed priority. For granted reads it returns memory read data with a one-cycle valid strobe.

## Interface
- ADDR_WIDTH, 6, memory address width
- DATA_WIDTH, 16, memory data width
- FIXED_PRIO, 0, 0 = round-robin on conflict; 1 = requester 0 always wins
- clk  input  1  system clock (same clock as memory)
- rst_n  input  1  reset; one clock, reset is synchronous and active-low
- req0, req1  input  1 each  access request; held high until granted
- we0, we1  input  1 each  1 = write, 0 = read; qualified by reqN
- addr0, addr1  input  ADDR_WIDTH each  access address
- wdata0, wdata1  input  DATA_WIDTH each  write data
- gnt0, gnt1  output  1 each  combinational grant; request consumed this cycle
- rdata0, rdata1  output  DATA_WIDTH each  read data, valid only with rvalidN
- rvalid0, rvalid1  output  1 each  registered read-return strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_WIDTH  memory address
- mem_data  output  DATA_WIDTH  memory write data
- mem_out  input  DATA_WIDTH  memory read data, registered inside the memory and valid the cycle after the address edge

## Operation
- State held in registers:
  - last_grant: 1 bit, the index of the most recently granted requester.
  - rd_pending: 2 bits, one per requester.
- Grant logic, combinational in cycle N:
  - Only req0 high: gnt0 = 1.
  - Only req1 high: gnt1 = 1.
  - Both high with FIXED_PRIO = 1: gnt0 = 1.
  - Both high with FIXED_PRIO = 0: grant the requester that is not last_grant.
  - At most one gnt is high in any cycle.
- Memory mux:
  - With gntN high: mem_addr = addrN, mem_data = wdataN, mem_we = weN.
  - With no grant: mem_we = 0, mem_addr = 0, mem_data = 0.
- At the clock edge ending cycle N:
  - last_grant is updated to the granted index if any grant occurred; otherwise it holds.
  - rd_pending[N] is set to gntN & ~weN.
- Read return:
  - rvalidN = rd_pending[N].
  - rdataN = mem_out, passed through; requesters sample when rvalidN = 1.
  - When rvalidN = 0, rdataN still follows mem_out and is don't-care.
- Write: the write completes at the grant edge. No rvalid is generated.
- Back-to-back traffic:
  - A requester holding req high with both requesting is granted on alternating cycles under round-robin.
  - Under FIXED_PRIO = 1 it is granted every cycle.
  - rvalid can be high for requester 0 in the same cycle as gnt1, so pipelined overlap is legal.
- Reset, rst_n = 0:
  - gnt0 = gnt1 = 0 and mem_we = 0 combinationally for the whole reset cycle, so no write can reach memory.
  - At the edge: last_grant = 1, so requester 0 wins the first conflict, and rd_pending = 00.
  - A read granted in the cycle before reset asserts is dropped: rvalid stays 0 after the reset edge.

## Timing
- Reset values:
  - gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, mem_we = 0.
  - mem_addr = 0 and mem_data = 0 unless a post-reset grant is active.
- Grant latency: 0 cycles (same cycle as req, if it wins).
- Read latency: rvalid and rdata arrive exactly 1 cycle after the grant cycle.
- Throughput: 1 access per cycle total.
- Worst-case wait under round-robin with both requesting continuously: 1 cycle.
- A request that is not granted must hold we, addr and wdata stable until granted.
- Simultaneous read by N and write by the other to the same address in consecutive cycles: the read sees memory contents as of its own grant edge, following memory read-before-write behaviour.

## Test plan
- Reset, then req0 = 1, we0 = 0, addr0 = 5 with mem[5] = 16'h1234: gnt0 = 1 in the same cycle; next cycle rvalid0 = 1, rdata0 = 16'h1234, and rvalid1 = 0.
- req1 write addr1 = 9, wdata1 = 16'hBEEF, then req0 reads addr 9: gnt1 and mem_we = 1 in cycle 0; gnt0 in cycle 1; rdata0 = 16'hBEEF with rvalid0 in cycle 2.
- FIXED_PRIO = 0, both requesting reads for 6 cycles right after reset: grants go 0,1,0,1,0,1 and rvalid alternates one cycle later.
- FIXED_PRIO = 1, both requesting for 4 cycles: gnt0 = 1 every cycle and gnt1 = 0 until req0 drops, then gnt1 = 1 in the same cycle.
- Assert rst_n = 0 during a cycle with req0 write to addr 3, wdata = 16'h00FF, with mem[3] = 0: gnt0 = 0 and mem_we = 0, and mem[3] stays 0.
- Read granted to requester 1 in cycle N, rst_n = 0 in cycle N+1: rvalid1 = 0 after the reset edge, and the next conflict grants requester 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
//   slave  : arbiter side (takes requests and mem_out; drives grants,
//            read returns and the memory command port)
//   master : requester/memory side (the mirror image)
// Requester signals: reqN, weN, addrN, wdataN -> gntN, rdataN, rvalidN
// Memory signals:    mem_we, mem_addr, mem_data -> memory; mem_out <- memory
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) ();
    logic                  req0, req1;
    logic                  we0, we1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0, gnt1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic                  rvalid0, rvalid1;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
               mem_we, mem_addr, mem_data
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
               mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory with a registered
// read port. One access is granted per clock (round-robin or fixed priority);
// granted reads come back one cycle later with an rvalid strobe.
// Ports:
//   clk    system clock, shared with the memory
//   rst_n  synchronous active-low reset
//   bus    mem_arbiter_if.slave: requester handshakes and memory port
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_arbiter_if.slave       bus
);

    logic       last_grant;
    logic [1:0] rd_pending;
    logic       gnt0_c;
    logic       gnt1_c;

    // Grants are forced low during the reset cycle so nothing reaches memory.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (rst_n) begin
            if (bus.req0 && bus.req1) begin
                if (FIXED_PRIO != 0) begin
                    gnt0_c = 1'b1;
                end else begin
                    // Favour whoever was not served last.
                    gnt0_c = last_grant;
                    gnt1_c = ~last_grant;
                end
            end else begin
                gnt0_c = bus.req0;
                gnt1_c = bus.req1;
            end
        end
    end

    always_comb begin
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_data = '0;
        if (gnt0_c) begin
            bus.mem_we   = bus.we0;
            bus.mem_addr = bus.addr0;
            bus.mem_data = bus.wdata0;
        end else if (gnt1_c) begin
            bus.mem_we   = bus.we1;
            bus.mem_addr = bus.addr1;
            bus.mem_data = bus.wdata1;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first conflict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            rd_pending <= 2'b00;
        end else begin
            if (gnt0_c) begin
                last_grant <= 1'b0;
            end else if (gnt1_c) begin
                last_grant <= 1'b1;
            end
            rd_pending <= {gnt1_c & ~bus.we1, gnt0_c & ~bus.we0};
        end
    end

    assign bus.gnt0    = gnt0_c;
    assign bus.gnt1    = gnt1_c;
    // Memory output is already registered; it lines up with rd_pending.
    assign bus.rdata0  = bus.mem_out;
    assign bus.rdata1  = bus.mem_out;
    assign bus.rvalid0 = rd_pending[0];
    assign bus.rvalid1 = rd_pending[1];

endmodule
